// File: rtl/usr_serdes_ctrl.sv
// usr_serdes_ctrl: sequences an external universal shift register as a shared
// serializer (TX, MSB first) and deserializer (RX, MSB first). The controller
// only drives sel/PI/SI and observes PO; the data itself lives in the register.
module usr_serdes_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [WIDTH-1:0] tx_data,
    output logic             ser_out,
    output logic             ser_out_valid,
    input  logic             ser_out_ready,
    input  logic             ser_in,
    input  logic             ser_in_valid,
    output logic             ser_in_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic [1:0]       usr_sel,
    output logic [WIDTH-1:0] usr_pi,
    output logic             usr_si,
    input  logic [WIDTH-1:0] usr_po,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHL  = 2'b01;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        TX_SHIFT,
        RX_SHIFT,
        RX_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Data paths are pure wiring: the register holds the word in both directions.
    assign usr_pi  = tx_data;
    assign usr_si  = ser_in;
    assign rx_data = usr_po;
    assign ser_out = usr_po[WIDTH-1];

    // State and accepted-bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and control outputs; reset masks every control output.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        usr_sel       = SEL_HOLD;
        tx_ready      = 1'b0;
        ser_in_ready  = 1'b0;
        ser_out_valid = 1'b0;
        rx_valid      = 1'b0;
        busy          = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                tx_ready     = 1'b1;
                // TX wins a tie; the offered RX bit simply waits.
                ser_in_ready = !tx_valid;
                if (tx_valid) begin
                    usr_sel = SEL_LOAD;
                    cnt_d   = '0;
                    state_d = TX_SHIFT;
                end else if (ser_in_valid) begin
                    usr_sel = SEL_SHL;
                    cnt_d   = CW'(1);
                    state_d = (WIDTH == 1) ? RX_DONE : RX_SHIFT;
                end
            end
            TX_SHIFT: begin
                ser_out_valid = 1'b1;
                // Without ready the register holds, so ser_out stays stable.
                if (ser_out_ready) begin
                    usr_sel = SEL_SHL;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d = IDLE;
                    end
                end
            end
            RX_SHIFT: begin
                ser_in_ready = 1'b1;
                if (ser_in_valid) begin
                    usr_sel = SEL_SHL;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d = RX_DONE;
                    end
                end
            end
            RX_DONE: begin
                rx_valid = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rst) begin
            usr_sel       = SEL_HOLD;
            tx_ready      = 1'b0;
            ser_in_ready  = 1'b0;
            ser_out_valid = 1'b0;
            rx_valid      = 1'b0;
            busy          = 1'b0;
        end
    end

endmodule

// File: doc/usr_serdes_ctrl.md
Name: usr_serdes_ctrl

Overview:
- Sequencer that drives a universal shift register (sel 00 hold, 01 shift left with SI into bit 0, 10 shift right, 11 parallel load) as a shared serializer/deserializer.
- Sits between a parallel word interface and a serial bit interface.
- Arbitrates the single register between a TX job (load, then shift out MSB-first) and an RX job (shift in MSB-first, then present the word).
- Only generates sel/PI/SI and observes PO; it holds no data copy.

Parameters:
WIDTH, 4, register width in bits; legal range 1 to 32.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst  input  1  synchronous, active-high reset.
tx_valid  input  1  parallel TX word offered.
tx_ready  output  1  TX word accepted this cycle when tx_valid&tx_ready.
tx_data  input  WIDTH  word to serialize.
ser_out  output  1  serial TX bit (MSB first).
ser_out_valid  output  1  ser_out is valid.
ser_out_ready  input  1  downstream consumes ser_out this cycle.
ser_in  input  1  serial RX bit (MSB first).
ser_in_valid  input  1  ser_in offered.
ser_in_ready  output  1  ser_in consumed this cycle when ser_in_valid&ser_in_ready.
rx_data  output  WIDTH  assembled RX word.
rx_valid  output  1  one-cycle pulse; rx_data valid.
usr_sel  output  2  mode to shift register.
usr_pi  output  WIDTH  parallel load value to shift register.
usr_si  output  1  serial input to shift register.
usr_po  input  WIDTH  current shift register contents.
busy  output  1  state != IDLE.

Behaviour:
- Reset is synchronous, active-high, clock clk; rst is shared with the shift register.
- On reset: state=IDLE, bit counter=0.
- While rst is high, all outputs are forced: usr_sel=00, tx_ready=0, ser_in_ready=0, ser_out_valid=0, rx_valid=0, busy=0.
- Reset mid-job abandons the job with no rx_valid.
- Control outputs are combinational from state, counter and handshake inputs.
- Counter width is clog2(WIDTH+1) and it counts accepted bits.
- usr_pi=tx_data at all times; usr_si=ser_in at all times. Both are don't-care unless selected.
- rx_data=usr_po at all times; meaningful only while rx_valid=1.
- States: IDLE, TX_SHIFT, RX_SHIFT, RX_DONE.
- IDLE:
  - tx_ready=1.
  - ser_in_ready=!tx_valid, so TX has priority.
  - If tx_valid: usr_sel=11 (load lands at this edge), cnt<=0, next TX_SHIFT.
  - Else if ser_in_valid: usr_sel=01 (first bit shifted in), cnt<=1, next RX_SHIFT, or RX_DONE if WIDTH==1.
  - Else usr_sel=00.
- TX_SHIFT:
  - ser_out=usr_po[WIDTH-1], ser_out_valid=1, tx_ready=0, ser_in_ready=0.
  - If ser_out_ready: usr_sel=01 and cnt++. When the WIDTH-th bit is accepted, next IDLE.
  - Else usr_sel=00 and ser_out is held stable (backpressure).
  - Latency: first bit is valid 1 cycle after tx handshake. Minimum WIDTH+1 cycles per word.
- RX_SHIFT:
  - ser_in_ready=1.
  - If ser_in_valid: usr_sel=01 and cnt++. When cnt reaches WIDTH, next RX_DONE.
  - Else usr_sel=00; gaps of any length are allowed.
- RX_DONE:
  - usr_sel=00, rx_valid=1 for exactly one cycle, ser_in_ready=0, tx_ready=0.
  - Next IDLE. There is no rx backpressure; the consumer must sample on the pulse.
- usr_sel=10 is never issued.
- ser_out_valid and rx_valid are never high in the same cycle.
- In IDLE with tx_valid and ser_in_valid both high, TX wins. ser_in_ready=0, so no RX bit is lost; the offered bit waits.
- No job preemption. An RX word in progress blocks TX until RX_DONE completes.

Test Plan:
1. WIDTH=4 with the shift register attached, ser_out_ready=1; tx_data=4'b1011 handshake at cycle 0 -> ser_out 1,0,1,1 in cycles 1-4 with ser_out_valid=1; tx_ready=1 again in cycle 5; usr_sel = 11,01,01,01,01,00.
2. Same word with ser_out_ready low in cycles 2-3 -> usr_sel=00 and ser_out=0 held for cycles 2-3; full sequence 1,0,1,1 still delivered; completion delayed by 2 cycles.
3. RX bits 1,1,0,1 offered with 1-cycle and 3-cycle gaps -> one rx_valid pulse with rx_data=4'b1101, then IDLE; no TX activity.
4. tx_valid=1 and ser_in_valid=1 together in IDLE -> tx_ready=1, ser_in_ready=0, TX of tx_data proceeds. RX bit is accepted only after TX returns to IDLE; later RX word is correct.
5. rst asserted after 2 TX bits -> next cycle state=IDLE, usr_sel=00, usr_po=0. A following TX of 4'b0110 serializes correctly as 0,1,1,0.
6. WIDTH=1: TX of 1 -> a single ser_out=1, then IDLE. A single RX bit 1 -> rx_valid on the next cycle with rx_data=1.
